// File: rtl/serial_addsub_n.sv
// serial_addsub_n: bit-serial adder/subtractor, LSB first, with start/busy/done handshake
module serial_addsub_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             sum_bit
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shift_a, shift_b, result_q;
    logic [CW-1:0]    cnt;
    logic             carry_q, c_msb, co, accept, last;

    assign sum_bit   = shift_a[0] ^ shift_b[0] ^ carry_q;
    assign co        = (shift_a[0] & shift_b[0]) | (shift_a[0] & carry_q) | (shift_b[0] & carry_q);
    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = carry_q ^ c_msb;

    // Sequencer decode: start is honoured outside SHIFT, SHIFT ends on the MSB cycle
    always_comb begin
        accept  = start && (state != SHIFT);
        last    = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
        state_n = accept ? SHIFT : (state == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Datapath: operand load on accept, one full-adder step per SHIFT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_a  <= '0;
            shift_b  <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            c_msb    <= 1'b0;
            cnt      <= '0;
        end else if (accept) begin
            shift_a <= data_a;
            shift_b <= sub ? ~data_b : data_b;
            carry_q <= sub;
            cnt     <= '0;
        end else if (state == SHIFT) begin
            shift_a  <= shift_a >> 1;
            shift_b  <= shift_b >> 1;
            result_q <= {sum_bit, result_q[WIDTH-1:1]};
            carry_q  <= co;
            cnt      <= cnt + 1'b1;
            if (last) c_msb <= carry_q;
        end
    end
endmodule

// File: tb/tb_serial_addsub_n.sv
// tb_serial_addsub_n: scoreboard bench over WIDTH = 8, 16 and 2 instances
module tb_serial_addsub_n;
    typedef struct {
        int          g;
        logic [31:0] r;
        logic        c;
        logic        v;
        int          t;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [2:0]            st  = '0;
    logic [2:0]            sb  = '0;
    logic [2:0][31:0]      da  = '0;
    logic [2:0][31:0]      db  = '0;
    logic [2:0]            bsy, dn, cy, ov, sbit;
    logic [2:0][31:0]      rs;
    exp_t                  sbq[$];
    int                    cyc = 0;
    int                    bc[3] = '{0, 0, 0};
    int                    vectors = 0;
    int                    miscompares = 0;

    function automatic int wof(input int g);
        return (g == 0) ? 8 : (g == 1) ? 16 : 2;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int W = (g == 0) ? 8 : (g == 1) ? 16 : 2;
        logic [W-1:0] r;
        serial_addsub_n #(.WIDTH(W)) dut (
            .clk(clk), .rst(rst), .start(st[g]), .sub(sb[g]),
            .data_a(da[g][W-1:0]), .data_b(db[g][W-1:0]),
            .busy(bsy[g]), .done(dn[g]), .result(r),
            .carry_out(cy[g]), .overflow(ov[g]), .sum_bit(sbit[g])
        );
        assign rs[g] = 32'(r);
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Monitor: count busy cycles per instance and check every done pulse against the queue
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rst) bc[g] = 0;
            else begin
                if (bsy[g]) bc[g]++;
                if (dn[g]) begin
                    vectors++;
                    if (sbq.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_done w=%0d cyc=%0d result=%0d", wof(g), cyc, rs[g]);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        if (e.g != g || rs[g] != e.r || cy[g] != e.c || ov[g] != e.v || cyc != e.t || bc[g] != wof(g)) begin
                            miscompares++;
                            $display("FAIL op w=%0d got inst=%0d res=%0d co=%0d ov=%0d cyc=%0d busy=%0d exp inst=%0d res=%0d co=%0d ov=%0d cyc=%0d busy=%0d",
                                     wof(g), g, rs[g], cy[g], ov[g], cyc, bc[g], e.g, e.r, e.c, e.v, e.t, wof(g));
                        end
                    end
                    bc[g] = 0;
                end
            end
        end
    end

    task automatic push(input int g, input int r, input bit c, input bit v);
        exp_t e;
        e.g = g; e.r = r; e.c = c; e.v = v; e.t = cyc + 1 + wof(g);
        sbq.push_back(e);
    endtask

    task automatic drive(input int g, input bit s, input int a, input int b);
        st[g] = 1'b1; sb[g] = s; da[g] = a; db[g] = b;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout pending=%0d required=0", sbq.size());
            sbq.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic op(input int g, input bit s, input int a, input int b, input int r, input bit c, input bit v);
        @(negedge clk);
        drive(g, s, a, b);
        push(g, r, c, v);
        @(negedge clk);
        st[g] = 1'b0;
        wait_empty();
    endtask

    task automatic chk_zero(input string tag);
        for (int g = 0; g < 3; g++) begin
            vectors++;
            if (bsy[g] || dn[g] || rs[g] != 0 || cy[g] || ov[g]) begin
                miscompares++;
                $display("FAIL %s w=%0d busy=%0d done=%0d res=%0d co=%0d ov=%0d required all 0",
                         tag, wof(g), bsy[g], dn[g], rs[g], cy[g], ov[g]);
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_zero("reset_state");
        rst = 1'b0;
        // WIDTH=8 directed vectors
        op(0, 0, 100, 55,  155, 0, 1);
        op(0, 0, 200, 100, 44,  1, 0);
        op(0, 1, 50,  20,  30,  1, 0);
        op(0, 1, 20,  50,  226, 0, 0);
        op(0, 1, 'h80, 'h01, 'h7F, 1, 1);
        op(0, 0, 'h7F, 'h01, 'h80, 0, 1);
        // start pulsed mid-SHIFT is ignored
        @(negedge clk);
        drive(0, 0, 10, 20);
        push(0, 30, 0, 0);
        @(negedge clk);
        st[0] = 1'b0;
        repeat (2) @(negedge clk);
        drive(0, 1, 99, 77);
        @(negedge clk);
        st[0] = 1'b0;
        wait_empty();
        repeat (10) @(negedge clk);
        // start held through DONE: second op launches back-to-back
        @(negedge clk);
        drive(0, 0, 5, 6);
        push(0, 11, 0, 0);
        repeat (9) @(negedge clk);
        drive(0, 1, 9, 4);
        push(0, 5, 1, 0);
        @(negedge clk);
        st[0] = 1'b0;
        wait_empty();
        // reset 3 cycles into an operation
        @(negedge clk);
        drive(0, 0, 7, 8);
        @(negedge clk);
        st[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero("mid_op_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        op(0, 0, 7, 8, 15, 0, 0);
        // WIDTH=16
        op(1, 0, 40000, 30000, 4464,  1, 0);
        op(1, 1, 1000,  3000,  63536, 0, 0);
        op(1, 1, 'h8000, 1,   'h7FFF, 1, 1);
        // WIDTH=2
        op(2, 0, 1, 1, 2, 0, 1);
        op(2, 0, 3, 3, 2, 1, 0);
        op(2, 1, 1, 2, 3, 0, 1);
        op(2, 1, 2, 1, 1, 1, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
